// File: rtl/wfg_mem_reader.sv
// Read initiator for the 1024-word waveform sample memory: walks an address window
// and streams words to the generator core. Optional one-shot mode: WFG_MEM_READER_ONESHOT_EN.
module wfg_mem_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ctrl_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [7:0]        step,
   output logic              csb,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] wfg_data,
   output logic              wfg_valid,
   input  logic              wfg_ready,
   output logic              busy,
   output logic              wrap,
`ifdef WFG_MEM_READER_ONESHOT_EN
   input  logic              oneshot,
   output logic              done,
`endif
   output logic [1:0]        state_dbg
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Stream handshake: a word transfers on any rising edge where wfg_valid and
   // wfg_ready are both high; wfg_data is held stable while valid waits for ready.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        step_q;
   logic              pending;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occupancy;
   logic [ADDR_W:0]   next_addr;
   logic              at_end;
   logic              issue;
   logic              flush;
   logic              push;
   logic              pop;
   logic              out_load;
   logic              fifo_wr;
   logic              fifo_rd;
   logic              last_issued;

`ifdef WFG_MEM_READER_ONESHOT_EN
   logic              oneshot_q;
`else
   assign last_issued = 1'b0;
`endif

   // wfg_data/wfg_valid act as an output stage in front of the FIFO, so the FIFO
   // plus the in-flight read bound what may be outstanding without costing throughput.
   always_comb begin
      occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending};
      next_addr = {1'b0, cur_addr} + (ADDR_W+1)'(step_q);
      at_end    = next_addr > {1'b0, end_q};
      issue     = (state == ST_RUN) && ctrl_en && !last_issued &&
                  (occupancy < (CNT_W+1)'(FIFO_DEPTH));
      flush     = (state != ST_RUN) || !ctrl_en;
      push      = pending && !flush;
      pop       = wfg_valid && wfg_ready;
      out_load  = !wfg_valid || pop;
      fifo_rd   = out_load && (fifo_count != '0);
      fifo_wr   = push && !(out_load && (fifo_count == '0));
   end

   assign csb       = !issue;
   assign addr      = cur_addr;
   assign wrap      = issue && at_end;
   assign busy      = (state == ST_RUN) || pending;
   assign state_dbg = state;

`ifdef WFG_MEM_READER_ONESHOT_EN
   assign done = (state == ST_RUN) && last_issued && pop && (fifo_count == '0) && !pending;
`endif

   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr] <= dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         start_q    <= '0;
         end_q      <= '0;
         step_q     <= 8'd1;
         cur_addr   <= '0;
         pending    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         wfg_data   <= '0;
         wfg_valid  <= 1'b0;
`ifdef WFG_MEM_READER_ONESHOT_EN
         oneshot_q   <= 1'b0;
         last_issued <= 1'b0;
`endif
      end else begin
         pending <= issue;
         case (state)
            ST_IDLE: begin
               // A read still in flight must land (and be dropped) before re-arming.
               if (ctrl_en && !pending) begin
                  state    <= ST_RUN;
                  start_q  <= start_addr;
                  end_q    <= end_addr;
                  step_q   <= (step == 8'd0) ? 8'd1 : step;
                  cur_addr <= start_addr;
`ifdef WFG_MEM_READER_ONESHOT_EN
                  oneshot_q   <= oneshot;
                  last_issued <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               if (issue) begin
                  cur_addr <= at_end ? start_q : next_addr[ADDR_W-1:0];
`ifdef WFG_MEM_READER_ONESHOT_EN
                  if (oneshot_q && at_end) last_issued <= 1'b1;
`endif
               end
               if (!ctrl_en) state <= ST_IDLE;
`ifdef WFG_MEM_READER_ONESHOT_EN
               else if (done) state <= ST_HALT;
`endif
            end
            ST_HALT: begin
               if (!ctrl_en) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wfg_valid  <= 1'b0;
         end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
            if (out_load) begin
               if (fifo_count != '0) begin
                  wfg_data  <= fifo_mem[rd_ptr];
                  wfg_valid <= 1'b1;
               end else if (push) begin
                  wfg_data  <= dout;
                  wfg_valid <= 1'b1;
               end else begin
                  wfg_valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wfg_mem_reader.sv
// Scoreboard bench for wfg_mem_reader: directed windows, expected issue and data queues,
// and a negedge monitor that compares every memory issue and every stream transfer.
module tb_wfg_mem_reader;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ctrl_en = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [ADDR_W-1:0] end_addr = '0;
   logic [7:0]        step = 8'd1;
   logic              csb;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] dout = '0;
   logic [DATA_W-1:0] wfg_data;
   logic              wfg_valid;
   logic              wfg_ready = 1'b1;
   logic              busy;
   logic              wrap;
   logic [1:0]        state_dbg;
`ifdef WFG_MEM_READER_ONESHOT_EN
   logic              oneshot = 1'b0;
   logic              done;
`endif

   wfg_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .ctrl_en(ctrl_en),
      .start_addr(start_addr), .end_addr(end_addr), .step(step),
      .csb(csb), .addr(addr), .dout(dout),
      .wfg_data(wfg_data), .wfg_valid(wfg_valid), .wfg_ready(wfg_ready),
      .busy(busy), .wrap(wrap),
`ifdef WFG_MEM_READER_ONESHOT_EN
      .oneshot(oneshot), .done(done),
`endif
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int n_pop = 0;

   logic [ADDR_W-1:0] exp_addr_q[$];
   logic              exp_wrap_q[$];
   logic [DATA_W-1:0] exp_q[$];

   logic [ADDR_W-1:0] pat_addr[4];
   logic              pat_wrap[4];

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return {22'd0, a} * 32'd3;
   endfunction

   // SRAM model: one-cycle read latency
   always @(posedge clk) begin
      if (!csb) dout <= mem_word(addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   logic [ADDR_W-1:0] mon_addr;
   logic              mon_wrap;
   logic              stall_prev = 1'b0;
   logic [DATA_W-1:0] stall_data = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (!csb) begin
            if (exp_addr_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL issue_unexpected: addr %h issued, none expected", addr);
            end else begin
               mon_addr = exp_addr_q.pop_front();
               mon_wrap = exp_wrap_q.pop_front();
               check("issue_addr", 32'(addr), 32'(mon_addr));
               check("issue_wrap", 32'(wrap), 32'(mon_wrap));
               exp_q.push_back(mem_word(mon_addr));
            end
         end else if (wrap) begin
            check("wrap_without_issue", 32'(wrap), 32'd0);
         end
         if (stall_prev && wfg_valid) check("stall_hold", wfg_data, stall_data);
         if (wfg_valid && wfg_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL stream_unexpected: got %h, no word expected", wfg_data);
            end else begin
               check("stream_data", wfg_data, exp_q.pop_front());
            end
         end
         stall_prev = wfg_valid && !wfg_ready;
         stall_data = wfg_data;
      end
   end

   // driver tasks
   task automatic set_window(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                             input logic [7:0] st);
      start_addr = s;
      end_addr   = e;
      step       = st;
   endtask

   task automatic load_pattern(input int n, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(pat_addr[i]);
            exp_wrap_q.push_back(pat_wrap[i]);
         end
      end
   endtask

   task automatic start_run();
      @(posedge clk);
      #1 ctrl_en = 1'b1;
   endtask

   task automatic clear_expect();
      exp_addr_q.delete();
      exp_wrap_q.delete();
      exp_q.delete();
   endtask

   task automatic stop_run();
      @(posedge clk);
      #1 ctrl_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("stop_valid", 32'(wfg_valid), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      clear_expect();
   endtask

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   int  lat;
   int  cnt_a;
   int  cnt_b;
   bit  found;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_csb", 32'(csb), 32'd1);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_valid", 32'(wfg_valid), 32'd0);
      check("rst_data", wfg_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_state", 32'(state_dbg), 32'd0);

      // basic stream, latency, throughput
      set_window(10'h000, 10'h003, 8'd1);
      pat_addr = '{10'h000, 10'h001, 10'h002, 10'h003};
      pat_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
      load_pattern(4, 30);
      wfg_ready = 1'b1;
      start_run();
      lat = 0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (!csb) found = 1'b1;
         else lat++;
      end
      check("issue_latency", 32'(lat), 32'd1);
      lat = 0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         lat++;
         if (wfg_valid) found = 1'b1;
      end
      check("valid_latency", 32'(lat), 32'd2);
      cnt_a = 0;
      cnt_b = 0;
      lat = 0;
      repeat (40) begin
         @(negedge clk);
         if (!wfg_valid) lat++;
         if (!csb) cnt_a++;
         if (wrap) cnt_b++;
      end
      check("no_bubble", 32'(lat), 32'd0);
      check("issue_rate", 32'(cnt_a), 32'd40);
      check("wrap_count", 32'(cnt_b), 32'd10);
      stop_run();

      // bank crossing with step 4
      set_window(10'h1FE, 10'h206, 8'd4);
      pat_addr = '{10'h1FE, 10'h202, 10'h206, 10'h000};
      pat_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
      load_pattern(3, 15);
      start_run();
      repeat (30) @(negedge clk);
      stop_run();

      // random backpressure
      set_window(10'h020, 10'h02A, 8'd3);
      pat_addr = '{10'h020, 10'h023, 10'h026, 10'h029};
      pat_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
      load_pattern(4, 60);
      cnt_a = n_pop;
      start_run();
      repeat (200) begin
         @(posedge clk);
         #1 wfg_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1 wfg_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bp_progress", 32'(n_pop - cnt_a > 40), 32'd1);
      stop_run();

      // stop in the cycle after an issue, then restart elsewhere
      set_window(10'h040, 10'h04F, 8'd1);
      pat_addr = '{10'h040, 10'h041, 10'h042, 10'h043};
      pat_wrap = '{1'b0, 1'b0, 1'b0, 1'b0};
      load_pattern(4, 1);
      start_run();
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (!csb) found = 1'b1;
      end
      check("stop_issue_seen", 32'(found), 32'd1);
      @(posedge clk);
      #1 ctrl_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("flush_valid", 32'(wfg_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 clear_expect();
      set_window(10'h100, 10'h103, 8'd1);
      pat_addr = '{10'h100, 10'h101, 10'h102, 10'h103};
      pat_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
      load_pattern(4, 10);
      start_run();
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (wfg_valid) found = 1'b1;
      end
      check("restart_first", wfg_data, mem_word(10'h100));
      repeat (20) @(negedge clk);
      stop_run();

      // degenerate window: start above end
      set_window(10'h010, 10'h008, 8'd5);
      pat_addr = '{10'h010, 10'h000, 10'h000, 10'h000};
      pat_wrap = '{1'b1, 1'b0, 1'b0, 1'b0};
      load_pattern(1, 30);
      start_run();
      repeat (20) @(negedge clk);
      stop_run();

      // step 0 acts as step 1
      set_window(10'h005, 10'h007, 8'd0);
      pat_addr = '{10'h005, 10'h006, 10'h007, 10'h000};
      pat_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
      load_pattern(3, 10);
      start_run();
      repeat (20) @(negedge clk);
      stop_run();

`ifdef WFG_MEM_READER_ONESHOT_EN
      // one-shot window
      oneshot = 1'b1;
      set_window(10'h000, 10'h002, 8'd1);
      pat_addr = '{10'h000, 10'h001, 10'h002, 10'h000};
      pat_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
      load_pattern(3, 1);
      start_run();
      cnt_a = 0;
      cnt_b = 0;
      repeat (20) begin
         @(negedge clk);
         if (wfg_valid && wfg_ready) cnt_a++;
         if (done) begin
            cnt_b++;
            check("done_on_last_pop", 32'(cnt_a), 32'd3);
         end
      end
      check("oneshot_words", 32'(cnt_a), 32'd3);
      check("oneshot_done", 32'(cnt_b), 32'd1);
      stop_run();
      oneshot = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
